// File: rtl/sa_pkg.sv
// sa_pkg: shared FSM state type and timing helpers for the systolic tile.
package sa_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;
    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction
endpackage

// File: rtl/sa_pe.sv
// sa_pe: signed MAC processing element with operand pass-through registers.
module sa_pe #(
    parameter int WIDTH = 8,
    parameter int C_WIDTH = 32
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic [WIDTH-1:0] a_in,
    input  logic a_vin,
    input  logic [WIDTH-1:0] w_in,
    input  logic w_vin,
    output logic [WIDTH-1:0] a_out,
    output logic a_vout,
    output logic [WIDTH-1:0] w_out,
    output logic w_vout,
    output logic [C_WIDTH-1:0] acc
);
    logic signed [2*WIDTH-1:0] prod;
    assign prod = (2*WIDTH)'($signed(a_in)) * (2*WIDTH)'($signed(w_in));
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_out <= '0;
            a_vout <= 1'b0;
            w_out <= '0;
            w_vout <= 1'b0;
            acc <= '0;
        end else begin
            a_out <= a_in;
            a_vout <= a_vin;
            w_out <= w_in;
            w_vout <= w_vin;
            acc <= clr ? '0 : (a_vin && w_vin) ? acc + C_WIDTH'(prod) : acc;
        end
    end
endmodule

// File: rtl/sa_tile_os.sv
// sa_tile_os: output-stationary ROWSxCOLS systolic MAC tile with skewed
// operand entry, run controller and back-pressured row-serial drain.
module sa_tile_os import sa_pkg::*; #(
    parameter int ROWS = 32,
    parameter int COLS = 32,
    parameter int WIDTH = 8,
    parameter int C_WIDTH = 32,
    parameter int KW = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic [KW-1:0] k_len,
    input  logic in_valid,
    output logic in_ready,
    input  logic [ROWS*WIDTH-1:0] act_in,
    input  logic [COLS*WIDTH-1:0] wgt_in,
    output logic out_valid,
    input  logic out_ready,
    output logic [$clog2(ROWS)-1:0] out_row,
    output logic [COLS*C_WIDTH-1:0] out_data,
    output logic out_last,
    output logic busy,
    output logic done
);
    localparam int RW = $clog2(ROWS);
    localparam int FL = flush_len(ROWS, COLS);
    localparam int FW = $clog2(FL);

    state_t state;
    logic [KW-1:0] cnt;
    logic [FW-1:0] fcnt;
    logic [RW-1:0] row;
    logic fire, clr;

    assign in_ready = state == STREAM;
    assign busy = state != IDLE;
    assign out_valid = state == DRAIN;
    assign out_row = row;
    assign out_last = out_valid && row == RW'(ROWS-1);
    assign fire = in_valid && in_ready;
    assign clr = state == IDLE && start;

    // {valid, data} words entering the grid edges after the diagonal skew
    logic [WIDTH:0] a_sk [ROWS];
    logic [WIDTH:0] w_sk [COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_ask
        if (r == 0) begin : g_d0
            assign a_sk[r] = {fire, act_in[r*WIDTH +: WIDTH]};
        end else begin : g_dn
            logic [WIDTH:0] sr [r];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < r; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= {fire, act_in[r*WIDTH +: WIDTH]};
                    for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
                end
            end
            assign a_sk[r] = sr[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_wsk
        if (c == 0) begin : g_d0
            assign w_sk[c] = {fire, wgt_in[c*WIDTH +: WIDTH]};
        end else begin : g_dn
            logic [WIDTH:0] sr [c];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < c; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= {fire, wgt_in[c*WIDTH +: WIDTH]};
                    for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
                end
            end
            assign w_sk[c] = sr[c-1];
        end
    end

    logic [WIDTH:0] ah [ROWS][COLS+1];
    logic [WIDTH:0] wv [ROWS+1][COLS];
    logic [C_WIDTH-1:0] acc [ROWS][COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign ah[r][0] = a_sk[r];
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (r == 0) begin : g_top
                assign wv[0][c] = w_sk[c];
            end
            sa_pe #(.WIDTH(WIDTH), .C_WIDTH(C_WIDTH)) u_pe (
                .clk(clk),
                .rstn(rstn),
                .clr(clr),
                .a_in(ah[r][c][WIDTH-1:0]),
                .a_vin(ah[r][c][WIDTH]),
                .w_in(wv[r][c][WIDTH-1:0]),
                .w_vin(wv[r][c][WIDTH]),
                .a_out(ah[r][c+1][WIDTH-1:0]),
                .a_vout(ah[r][c+1][WIDTH]),
                .w_out(wv[r+1][c][WIDTH-1:0]),
                .w_vout(wv[r+1][c][WIDTH]),
                .acc(acc[r][c])
            );
        end
    end

    always_comb begin
        for (int c = 0; c < COLS; c++) out_data[c*C_WIDTH +: C_WIDTH] = acc[row][c];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt <= '0;
            fcnt <= '0;
            row <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt <= k_len;
                    state <= (k_len != '0) ? STREAM : DRAIN;
                end
                STREAM: if (fire) begin
                    cnt <= cnt - KW'(1);
                    if (cnt == KW'(1)) begin
                        state <= FLUSH;
                        fcnt <= '0;
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt + FW'(1);
                    if (fcnt == FW'(FL-1)) state <= DRAIN;
                end
                DRAIN: if (out_ready) begin
                    row <= row + RW'(1);
                    if (row == RW'(ROWS-1)) begin
                        row <= '0;
                        state <= IDLE;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_tile_os.sv
// tb_sa_tile_os: directed table-driven bench for a 4x4 tile, with a 16-bit
// accumulator twin sharing the same stimulus for wrap-around checks.
module tb_sa_tile_os;
    typedef struct {
        int k;
        logic [3:0] vpat;
        logic [3:0][31:0] act;
        logic [3:0][31:0] wgt;
        logic [3:0][127:0] exp;
        int lat;
    } vec_t;

    logic clk = 1'b0, rstn, start, in_valid, out_ready;
    logic [15:0] k_len;
    logic [31:0] act_in, wgt_in;
    logic in_ready, out_valid, out_last, busy, done;
    logic [1:0] out_row;
    logic [127:0] out_data;
    logic in_ready16, out_valid16, out_last16, busy16, done16;
    logic [1:0] out_row16;
    logic [63:0] out_data16;
    int checks = 0, errors = 0;
    vec_t tbl [5];
    vec_t v;

    always #5 clk = ~clk;

    sa_tile_os #(.ROWS(4), .COLS(4), .WIDTH(8), .C_WIDTH(32), .KW(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .wgt_in(wgt_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    sa_tile_os #(.ROWS(4), .COLS(4), .WIDTH(8), .C_WIDTH(16), .KW(16)) dut16 (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready16), .act_in(act_in), .wgt_in(wgt_in),
        .out_valid(out_valid16), .out_ready(out_ready), .out_row(out_row16),
        .out_data(out_data16), .out_last(out_last16), .busy(busy16), .done(done16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] row4(input int c0, input int c1, input int c2, input int c3);
        return {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
    endfunction

    function automatic logic [63:0] trunc16(input logic [127:0] e);
        logic [63:0] r;
        for (int c = 0; c < 4; c++) r[c*16 +: 16] = e[c*32 +: 16];
        return r;
    endfunction

    task automatic chk_reset();
        chk("rst_ctl", {in_ready, out_valid, out_row, out_last, busy, done}, '0);
        chk("rst_data", out_data, '0);
        chk("rst_ctl16", {in_ready16, out_valid16, out_row16, out_last16, busy16, done16}, '0);
        chk("rst_data16", out_data16, '0);
    endtask

    task automatic run(input vec_t t, input int stall_row, input int stall_n, input bit poke);
        int lat, idx, p, n;
        start = 1'b1;
        k_len = 16'(t.k);
        tick();
        start = 1'b0;
        lat = 1;
        chk("busy_start", busy, 1);
        chk("in_ready_start", in_ready, t.k != 0);
        idx = 0;
        p = 0;
        while (idx < t.k && p < 64) begin
            in_valid = t.vpat[p % 4];
            act_in = t.act[idx];
            wgt_in = t.wgt[idx];
            chk("in_ready", in_ready, 1);
            tick();
            lat++;
            if (in_valid) idx++;
            p++;
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 64) begin
            tick();
            lat++;
            n++;
        end
        chk("latency", lat, t.lat);
        for (int i = 0; i < 4; i++) begin
            if (i == stall_row) begin
                out_ready = 1'b0;
                for (int j = 0; j < stall_n; j++) begin
                    start = poke;
                    k_len = 16'd4;
                    chk("stall_row", {out_valid, out_row}, {1'b1, 2'(i)});
                    chk("stall_data", out_data, t.exp[i]);
                    tick();
                end
                start = 1'b0;
                out_ready = 1'b1;
            end
            chk("row_ctl", {out_valid, out_row, out_last, busy, done}, {1'b1, 2'(i), i == 3, 1'b1, 1'b0});
            chk("row_data", out_data, t.exp[i]);
            chk("row_ctl16", {out_valid16, out_row16, out_last16}, {1'b1, 2'(i), i == 3});
            chk("row_data16", out_data16, trunc16(t.exp[i]));
            tick();
        end
        chk("done", {done, busy, out_valid, done16}, 4'b1001);
        tick();
        chk("done_once", {done, busy, in_ready, out_valid, done16, busy16}, '0);
    endtask

    initial begin
        tbl[0] = '{4, 4'b1111,
                   {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001},
                   {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201},
                   {row4(13, 14, 15, 16), row4(9, 10, 11, 12), row4(5, 6, 7, 8), row4(1, 2, 3, 4)},
                   12};
        tbl[1] = tbl[0];
        tbl[1].vpat = 4'b0101;
        tbl[1].lat = 15;
        tbl[2] = '{1, 4'b1111, {96'h0, 32'h80808080}, {96'h0, 32'h80808080},
                   {4{row4(16384, 16384, 16384, 16384)}}, 9};
        tbl[3] = '{2, 4'b1111, {64'h0, 32'h80808080, 32'h80808080}, {64'h0, 32'h80808080, 32'h80808080},
                   {4{row4(32768, 32768, 32768, 32768)}}, 10};
        tbl[4] = '{2, 4'b1101, {64'h0, 32'hFFFFFFFF, 32'h04030201}, {64'h0, 32'h01FD000A, 32'h0705FEFF},
                   {row4(-14, -8, 23, 27), row4(-13, -6, 18, 20), row4(-12, -4, 13, 13), row4(-11, -2, 8, 6)},
                   11};

        rstn = 1'b0;
        start = 1'b0;
        k_len = '0;
        in_valid = 1'b0;
        act_in = '0;
        wgt_in = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        chk_reset();
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run(tbl[i], -1, 0, 1'b0);

        // row 1 held back for five cycles
        run(tbl[0], 1, 5, 1'b0);

        // empty run; start poked while draining must not restart
        v = '{0, 4'b1111, '0, '0, '0, 1};
        run(v, 2, 2, 1'b1);

        // reset in the middle of a stream
        start = 1'b1;
        k_len = 16'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        act_in = 32'h05050505;
        wgt_in = 32'h03030303;
        repeat (2) tick();
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk_reset();
        tick();
        rstn = 1'b1;
        tick();
        chk_reset();
        v = '{1, 4'b1111, {96'h0, 32'h01010101}, {96'h0, 32'h01010101}, {4{row4(1, 1, 1, 1)}}, 9};
        run(v, -1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
